// File: rtl/ascii_cmd_pkg.sv
// Shared constants and encodings for the ASCII valve command parser:
// character codes, parser states, character classes and error codes.
package ascii_cmd_pkg;

    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_1    = 8'h31;
    localparam logic [7:0] CH_M    = 8'h6D;
    localparam logic [7:0] CH_M_UC = 8'h4D;
    localparam logic [7:0] CH_S    = 8'h73;
    localparam logic [7:0] CH_S_UC = 8'h53;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BITS      = 2'd1,
        TERM_WAIT = 2'd2,
        DISCARD   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CLS_OTHER = 2'd0,
        CLS_DIGIT = 2'd1,
        CLS_MODE  = 2'd2,
        CLS_TERM  = 2'd3
    } char_class_t;

    localparam logic [1:0] ERR_CHAR    = 2'b01;
    localparam logic [1:0] ERR_LEN     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/ascii_char_class.sv
// Combinational byte decoder: classifies a received byte and extracts the
// digit value ('0'/'1') and the mode bit ('s'/'S' = sequence).
module ascii_char_class
    import ascii_cmd_pkg::*;
(
    input  logic [7:0] data,
    output logic [1:0] char_class,
    output logic       digit_bit,
    output logic       mode_bit
);

    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        char_class = CLS_OTHER;
        digit_bit  = 1'b0;
        mode_bit   = 1'b0;
        case (data)
            CH_0, CH_1: begin
                char_class = CLS_DIGIT;
                digit_bit  = data[0];
            end
            CH_M, CH_M_UC: begin
                char_class = CLS_MODE;
            end
            CH_S, CH_S_UC: begin
                char_class = CLS_MODE;
                mode_bit   = 1'b1;
            end
            CH_CR, CH_LF: begin
                char_class = CLS_TERM;
            end
            default: begin
                char_class = CLS_OTHER;
            end
        endcase
    end

endmodule

// File: rtl/ascii_valve_cmd_parser.sv
// Frame parser: <mode><N_VALVES digits><CR|LF> -> registered valve mask and
// mode, with one error pulse per bad, wrong-length or stalled frame.
module ascii_valve_cmd_parser
    import ascii_cmd_pkg::*;
#(
    parameter int N_VALVES       = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [N_VALVES-1:0] valve_mask,
    output logic                cmd_mode,
    output logic                cmd_valid,
    output logic                cmd_error,
    output logic [1:0]          err_code,
    output logic                busy
);

    localparam int CNT_W = $clog2(N_VALVES + 1);
    localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_VALVES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  =
        TO_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    state_t               state_q, state_d;
    logic [N_VALVES-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 mode_pend_q, mode_pend_d;
    logic [TO_W-1:0]      to_q, to_d;
    logic [N_VALVES-1:0]  mask_d;
    logic                 mode_d;
    logic                 valid_d;
    logic                 error_d;
    logic [1:0]           code_d;
    logic                 busy_d;

    logic [1:0]           cls_raw;
    char_class_t          cls;
    logic                 digit_bit;
    logic                 mode_bit;
    logic                 timeout_hit;

    ascii_char_class u_char_class (
        .data       (rx_data),
        .char_class (cls_raw),
        .digit_bit  (digit_bit),
        .mode_bit   (mode_bit)
    );

    assign cls         = char_class_t'(cls_raw);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_q == TO_LAST);

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        mode_pend_d = mode_pend_q;
        to_d        = to_q;
        mask_d      = valve_mask;
        mode_d      = cmd_mode;
        valid_d     = 1'b0;
        error_d     = 1'b0;
        code_d      = err_code;

        if (TIMEOUT_CYCLES != 0 && state_q != IDLE) begin
            to_d = to_q + 1'b1;
        end

        if (rx_valid) begin
            // A byte always wins over a timeout expiring in the same cycle.
            to_d = '0;
            case (state_q)
                IDLE: begin
                    case (cls)
                        CLS_MODE: begin
                            mode_pend_d = mode_bit;
                            shift_d     = '0;
                            cnt_d       = '0;
                            state_d     = BITS;
                        end
                        CLS_TERM: begin
                            state_d = IDLE;
                        end
                        default: begin
                            error_d = 1'b1;
                            code_d  = ERR_CHAR;
                            state_d = DISCARD;
                        end
                    endcase
                end
                BITS: begin
                    case (cls)
                        CLS_DIGIT: begin
                            shift_d = (shift_q << 1) | N_VALVES'(digit_bit);
                            cnt_d   = cnt_q + 1'b1;
                            if (cnt_q == CNT_LAST) begin
                                state_d = TERM_WAIT;
                            end
                        end
                        CLS_TERM: begin
                            error_d = 1'b1;
                            code_d  = ERR_LEN;
                            state_d = IDLE;
                        end
                        default: begin
                            error_d = 1'b1;
                            code_d  = ERR_CHAR;
                            state_d = DISCARD;
                        end
                    endcase
                end
                TERM_WAIT: begin
                    case (cls)
                        CLS_TERM: begin
                            valid_d = 1'b1;
                            mask_d  = shift_q;
                            mode_d  = mode_pend_q;
                            state_d = IDLE;
                        end
                        CLS_DIGIT: begin
                            error_d = 1'b1;
                            code_d  = ERR_LEN;
                            state_d = DISCARD;
                        end
                        default: begin
                            error_d = 1'b1;
                            code_d  = ERR_CHAR;
                            state_d = DISCARD;
                        end
                    endcase
                end
                DISCARD: begin
                    if (cls == CLS_TERM) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else if (timeout_hit && state_q != IDLE) begin
            // A stalled discard is already flagged, so it returns silently.
            if (state_q != DISCARD) begin
                error_d = 1'b1;
                code_d  = ERR_TIMEOUT;
            end
            state_d = IDLE;
        end

        if (state_d == IDLE) begin
            to_d = '0;
        end

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            mode_pend_q <= 1'b0;
            to_q        <= '0;
            valve_mask  <= '0;
            cmd_mode    <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_error   <= 1'b0;
            err_code    <= 2'b00;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            mode_pend_q <= mode_pend_d;
            to_q        <= to_d;
            valve_mask  <= mask_d;
            cmd_mode    <= mode_d;
            cmd_valid   <= valid_d;
            cmd_error   <= error_d;
            err_code    <= code_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_ascii_valve_cmd_parser.sv
// Self-checking bench for ascii_valve_cmd_parser (N_VALVES=4, TIMEOUT_CYCLES=16)
// using a frame-level reference model and randomized frames.
module tb_ascii_valve_cmd_parser;

    localparam int N  = 4;
    localparam int TO = 16;

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic [7:0]   rx_data  = 8'h00;
    logic         rx_valid = 1'b0;
    logic [N-1:0] valve_mask;
    logic         cmd_mode;
    logic         cmd_valid;
    logic         cmd_error;
    logic [1:0]   err_code;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0] exp_mask = '0;
    logic         exp_mode = 1'b0;
    logic [1:0]   exp_code = 2'b00;
    logic [7:0]   frame_q[$];

    always #5 clk = ~clk;

    ascii_valve_cmd_parser #(
        .N_VALVES       (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .valve_mask (valve_mask),
        .cmd_mode   (cmd_mode),
        .cmd_valid  (cmd_valid),
        .cmd_error  (cmd_error),
        .err_code   (err_code),
        .busy       (busy)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit is_mode(input logic [7:0] b);
        return b inside {8'h6D, 8'h4D, 8'h73, 8'h53};
    endfunction

    function automatic bit is_digit(input logic [7:0] b);
        return b inside {8'h30, 8'h31};
    endfunction

    function automatic void load_str(input string s, input logic [7:0] term);
        for (int i = 0; i < s.len(); i++) frame_q.push_back(s[i]);
        frame_q.push_back(term);
    endfunction

    // One clock: drive inputs at the falling edge, settle just after the rising edge.
    task automatic drive_cycle(input logic v, input logic [7:0] d);
        @(negedge clk);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Sends frame_q (exactly one terminator, at the end) starting from IDLE and
    // checks every cycle against outcomes derived from the frame's positions.
    task automatic run_frame(input string tag, input int gap_max);
        int           n, t;
        int           kind[$];
        logic [1:0]   code[$];
        bit           bad;
        logic [N-1:0] new_mask;
        n = frame_q.size();
        t = n - 1;
        bad = 1'b0;
        new_mask = '0;
        for (int i = 0; i < n; i++) begin
            kind.push_back(0);
            code.push_back(2'b00);
        end
        if (t > 0) begin
            if (!is_mode(frame_q[0])) begin
                kind[0] = 2; code[0] = 2'b01; bad = 1'b1;
            end
            for (int i = 1; i < t; i++) begin
                if (!bad) begin
                    if (i <= N) begin
                        if (!is_digit(frame_q[i])) begin
                            kind[i] = 2; code[i] = 2'b01; bad = 1'b1;
                        end
                    end else begin
                        kind[i] = 2;
                        code[i] = is_digit(frame_q[i]) ? 2'b10 : 2'b01;
                        bad = 1'b1;
                    end
                end
            end
            if (!bad) begin
                if (t - 1 < N) begin
                    kind[t] = 2; code[t] = 2'b10;
                end else begin
                    kind[t] = 1;
                    for (int k = 0; k < N; k++) new_mask[N-1-k] = (frame_q[1+k] == 8'h31);
                end
            end
        end

        for (int i = 0; i < n; i++) begin
            int gaps;
            gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            for (int g = 0; g <= gaps; g++) begin
                bit   is_byte;
                logic ev_v, ev_e, ev_busy;
                is_byte = (g == gaps);
                drive_cycle(is_byte, is_byte ? frame_q[i] : 8'h00);
                ev_v = is_byte && (kind[i] == 1);
                ev_e = is_byte && (kind[i] == 2);
                if (ev_v) begin
                    exp_mask = new_mask;
                    exp_mode = frame_q[0] inside {8'h73, 8'h53};
                end
                if (ev_e) exp_code = code[i];
                ev_busy = is_byte ? (i != t) : (i != 0);
                n_checks++;
                if ({cmd_valid, cmd_error, err_code, valve_mask, cmd_mode, busy} !==
                    {ev_v, ev_e, exp_code, exp_mask, exp_mode, ev_busy}) begin
                    n_fail++;
                    $display("FAIL %s byte %0d: valid/error/code/mask/mode/busy got %b/%b/%b/%b/%b/%b want %b/%b/%b/%b/%b/%b",
                             tag, i, cmd_valid, cmd_error, err_code, valve_mask, cmd_mode, busy,
                             ev_v, ev_e, exp_code, exp_mask, exp_mode, ev_busy);
                end
            end
        end
        frame_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({valve_mask, cmd_mode, cmd_valid, cmd_error, err_code, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: mask=%b mode=%b valid=%b error=%b code=%b busy=%b, want all 0",
                     valve_mask, cmd_mode, cmd_valid, cmd_error, err_code, busy);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_good_frame();
        load_str("m1010", 8'h0D);
        run_frame("good_m1010", 0);
        n_checks++;
        if ({valve_mask, cmd_mode, busy} !== {4'b1010, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL good_frame_result: mask=%b mode=%b busy=%b want 1010/0/0", valve_mask, cmd_mode, busy);
        end
    endtask

    task automatic test_short_frame();
        load_str("S0111", 8'h0A);
        run_frame("good_S0111", 1);
        load_str("s01", 8'h0D);
        run_frame("short_s01", 1);
        n_checks++;
        if ({valve_mask, cmd_mode, err_code} !== {4'b0111, 1'b1, 2'b10}) begin
            n_fail++;
            $display("FAIL short_frame_hold: mask=%b mode=%b code=%b want 0111/1/10", valve_mask, cmd_mode, err_code);
        end
    endtask

    task automatic test_bad_char();
        load_str("m10x1", 8'h0D);
        run_frame("badchar_m10x1", 0);
        n_checks++;
        if (err_code !== 2'b01) begin
            n_fail++;
            $display("FAIL bad_char_code: err_code=%b want 01", err_code);
        end
        load_str("s1111", 8'h0D);
        run_frame("good_s1111", 0);
        n_checks++;
        if ({valve_mask, cmd_mode} !== {4'b1111, 1'b1}) begin
            n_fail++;
            $display("FAIL after_bad_char: mask=%b mode=%b want 1111/1", valve_mask, cmd_mode);
        end
    endtask

    task automatic test_long_frame();
        load_str("m11110", 8'h0D);
        run_frame("long_m11110", 0);
        n_checks++;
        if ({valve_mask, err_code} !== {4'b1111, 2'b10}) begin
            n_fail++;
            $display("FAIL long_frame: mask=%b code=%b want 1111/10", valve_mask, err_code);
        end
        load_str("1", 8'h0D);
        run_frame("idle_digit", 0);
        load_str("", 8'h0A);
        run_frame("blank_line", 2);
        n_checks++;
        if ({err_code, busy} !== {2'b01, 1'b0}) begin
            n_fail++;
            $display("FAIL idle_digit_resync: code=%b busy=%b want 01/0", err_code, busy);
        end
    endtask

    task automatic test_timeout();
        drive_cycle(1'b1, 8'h6D);
        drive_cycle(1'b1, 8'h31);
        drive_cycle(1'b1, 8'h30);
        for (int k = 1; k <= TO + 4; k++) begin
            logic exp_e, exp_b;
            drive_cycle(1'b0, 8'h00);
            exp_e = (k == TO);
            exp_b = (k < TO);
            if (exp_e) exp_code = 2'b11;
            n_checks++;
            if ({cmd_error, cmd_valid, busy, err_code} !== {exp_e, 1'b0, exp_b, exp_code}) begin
                n_fail++;
                $display("FAIL timeout cycle %0d: error/valid/busy/code got %b/%b/%b/%b want %b/0/%b/%b",
                         k, cmd_error, cmd_valid, busy, err_code, exp_e, exp_b, exp_code);
            end
        end
    endtask

    task automatic test_timeout_suppress();
        drive_cycle(1'b1, 8'h6D);
        drive_cycle(1'b1, 8'h31);
        drive_cycle(1'b1, 8'h30);
        for (int k = 1; k < TO; k++) drive_cycle(1'b0, 8'h00);
        drive_cycle(1'b1, 8'h31);
        n_checks++;
        if ({cmd_error, cmd_valid, busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL timeout_suppress: error/valid/busy got %b/%b/%b want 0/0/1", cmd_error, cmd_valid, busy);
        end
        drive_cycle(1'b1, 8'h30);
        drive_cycle(1'b1, 8'h0D);
        exp_mask = 4'b1010;
        exp_mode = 1'b0;
        n_checks++;
        if ({cmd_valid, cmd_error, valve_mask, cmd_mode} !== {1'b1, 1'b0, 4'b1010, 1'b0}) begin
            n_fail++;
            $display("FAIL suppressed_frame: valid/error/mask/mode got %b/%b/%b/%b want 1/0/1010/0",
                     cmd_valid, cmd_error, valve_mask, cmd_mode);
        end
    endtask

    task automatic test_discard_timeout();
        drive_cycle(1'b1, 8'h78);
        exp_code = 2'b01;
        n_checks++;
        if ({cmd_error, err_code} !== {1'b1, 2'b01}) begin
            n_fail++;
            $display("FAIL discard_entry: error/code got %b/%b want 1/01", cmd_error, err_code);
        end
        for (int k = 1; k <= TO + 4; k++) begin
            logic exp_b;
            drive_cycle(1'b0, 8'h00);
            exp_b = (k < TO);
            n_checks++;
            if ({cmd_error, cmd_valid, busy, err_code} !== {1'b0, 1'b0, exp_b, 2'b01}) begin
                n_fail++;
                $display("FAIL discard_timeout cycle %0d: error/valid/busy/code got %b/%b/%b/%b want 0/0/%b/01",
                         k, cmd_error, cmd_valid, busy, err_code, exp_b);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        drive_cycle(1'b1, 8'h73);
        drive_cycle(1'b1, 8'h31);
        drive_cycle(1'b1, 8'h30);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({valve_mask, cmd_mode, cmd_valid, cmd_error, err_code, busy} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: mask=%b mode=%b valid=%b error=%b code=%b busy=%b want all 0",
                     valve_mask, cmd_mode, cmd_valid, cmd_error, err_code, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_mask = '0;
        exp_mode = 1'b0;
        exp_code = 2'b00;
        load_str("m0001", 8'h0D);
        run_frame("after_reset_m0001", 0);
        n_checks++;
        if (valve_mask !== 4'b0001) begin
            n_fail++;
            $display("FAIL after_reset_mask: mask=%b want 0001", valve_mask);
        end
    endtask

    task automatic test_back_to_back();
        load_str("s1100", 8'h0D);
        run_frame("b2b_first", 0);
        load_str("m0011", 8'h0A);
        run_frame("b2b_second", 0);
        load_str("M01", 8'h0A);
        run_frame("b2b_short", 0);
        load_str("S1001", 8'h0D);
        run_frame("b2b_third", 0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 60; f++) begin
            int          sel;
            logic [7:0]  b;
            logic [7:0]  modes[4];
            modes[0] = 8'h6D; modes[1] = 8'h4D; modes[2] = 8'h73; modes[3] = 8'h53;
            sel = int'($urandom_range(0, 7));
            if (sel != 4) begin
                frame_q.push_back(modes[$urandom_range(0, 3)]);
                for (int k = 0; k < N; k++) frame_q.push_back($urandom_range(0, 1) != 0 ? 8'h31 : 8'h30);
                if (sel == 1) begin
                    b = 8'($urandom_range(0, 255));
                    if (b == 8'h0D || b == 8'h0A) b = 8'h7E;
                    frame_q[$urandom_range(0, N)] = b;
                end else if (sel == 2) begin
                    void'(frame_q.pop_back());
                end else if (sel == 3) begin
                    frame_q.push_back($urandom_range(0, 1) != 0 ? 8'h31 : 8'h30);
                end
            end
            frame_q.push_back($urandom_range(0, 1) != 0 ? 8'h0D : 8'h0A);
            run_frame("random", int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_short_frame();
        test_bad_char();
        test_long_frame();
        test_timeout();
        test_timeout_suppress();
        test_discard_timeout();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ascii_valve_cmd_parser.md
Name: ascii_valve_cmd_parser

Overview:
Sequential ASCII command-frame parser between the UART receiver and the valve driver logic. It consumes one received byte per strobe and assembles frames of the form <mode char><N_VALVES digits '0'/'1'><CR or LF>. Each complete frame produces a registered valve mask plus a mode bit. Malformed frames, wrong-length frames and stalled frames are flagged, and the block resynchronises at the next line terminator.

Parameters:
N_VALVES, 8, number of valve digits per frame and the width of valve_mask; legal range 1..32.
TIMEOUT_CYCLES, 1000000, clk cycles allowed between bytes inside a frame; 0 disables the timeout.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  asynchronous, active-high reset.
rx_data  input  8  received ASCII byte; sampled only when rx_valid=1.
rx_valid  input  1  one-cycle strobe per received byte.
valve_mask  output  N_VALVES  last accepted mask; the first digit received maps to bit N_VALVES-1.
cmd_mode  output  1  last accepted mode: 0='m'/'M' (manual), 1='s'/'S' (sequence).
cmd_valid  output  1  one-cycle pulse when valve_mask/cmd_mode update.
cmd_error  output  1  one-cycle pulse on a frame error.
err_code  output  2  cause of the error; valid while cmd_error=1. 01=bad char, 10=bad length, 11=timeout. Holds its last value otherwise.
busy  output  1  high while the parser is in any state other than IDLE.

Behaviour:
- Reset (asynchronous):
  - state=IDLE.
  - valve_mask, cmd_mode, cmd_valid, cmd_error, err_code, busy, bit counter, shift register and timeout counter all = 0.
- Character classes:
  - DIGIT: 0x30, 0x31.
  - MODE: 0x6D, 0x4D, 0x73, 0x53.
  - TERM: 0x0D, 0x0A.
  - OTHER: every remaining byte.
- All outputs are registered. cmd_valid/cmd_error assert on the cycle after the rx_valid that triggered them, and valve_mask/cmd_mode change in that same cycle.
- The shift register and pending mode are internal. Outputs change only on cmd_valid, so a partial or bad frame never disturbs valve_mask.
- IDLE:
  - MODE: latch mode, clear the shift register, count=0, go to BITS.
  - TERM: ignore (blank lines are legal).
  - DIGIT or OTHER: error 01, go to DISCARD.
- BITS:
  - DIGIT: shift left inserting bit0, count+1. On the N_VALVES-th digit go to TERM_WAIT.
  - TERM: error 10 (short frame), go to IDLE.
  - MODE or OTHER: error 01, go to DISCARD.
- TERM_WAIT:
  - TERM: pulse cmd_valid, load valve_mask and cmd_mode, go to IDLE.
  - DIGIT: error 10 (long frame), go to DISCARD.
  - MODE or OTHER: error 01, go to DISCARD.
- DISCARD:
  - TERM: go to IDLE with no pulse.
  - All other bytes: ignored, no further errors (at most one error per frame).
- Timeout:
  - The counter clears on every rx_valid and on entry to IDLE, and increments in BITS/TERM_WAIT/DISCARD.
  - When it reaches TIMEOUT_CYCLES-1 in BITS/TERM_WAIT: error 11, go to IDLE.
  - In DISCARD: silent return to IDLE.
  - If rx_valid arrives in the same cycle as the timeout would fire, the byte is processed and the timeout does not fire.
- cmd_valid and cmd_error are never high in the same cycle.
- rx_valid on back-to-back cycles is supported: one byte per clk.
- Reset mid-frame discards the frame. The outputs return to 0, not to the last accepted command.

Decomposition:
- Package ascii_cmd_pkg:
  - ASCII constants (CH_0, CH_1, CH_M, CH_M_UC, CH_S, CH_S_UC, CH_CR, CH_LF).
  - State encoding: IDLE, BITS, TERM_WAIT, DISCARD.
  - Character-class encoding.
  - err_code constants: ERR_CHAR, ERR_LEN, ERR_TIMEOUT.
- Sub-module ascii_char_class: a combinational byte-to-class decoder, which also outputs the digit bit value and the mode bit.
- The parser FSM, counters and output registers stay in the top block.

Test Plan:
- N_VALVES=4. Bytes "m1010\r" -> one cmd_valid the cycle after '\r', valve_mask=4'b1010, cmd_mode=0, busy=0 afterwards.
- After a good "S0111\n", send "s01\r" -> cmd_error with err_code=10. valve_mask stays 4'b0111 and cmd_mode stays 1.
- "m10x1\r" -> a single cmd_error with err_code=01 on the 'x'. Then "s1111\r" -> cmd_valid, mask=4'b1111, cmd_mode=1.
- "m11110\r" -> err_code=10 on the fifth digit and no cmd_valid. "1\r" sent from IDLE -> err_code=01, then silent resync.
- TIMEOUT_CYCLES=16: "m10" then idle -> cmd_error with err_code=11 exactly 16 cycles after the last rx_valid, then busy=0. A byte landing on the expiry cycle suppresses the timeout.
- Assert rst during "s10" -> all outputs 0 immediately, with no clock edge needed. After release, "m0001\r" -> mask=4'b0001. Back-to-back rx_valid across all 6 bytes is accepted.
